// File: rtl/wb_arbiter_2m_if.sv
// Wishbone bus bundle shared by the arbiter's master-facing and slave-facing ports.
// The master modport drives the request side; the slave modport drives the response side.
interface wshb_if;
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic [31:0] dat_sm;
  logic [3:0]  sel;
  logic        we;
  logic        stb;
  logic        cyc;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;
  logic        err;
  logic        rty;

  modport master (
    output adr, dat_ms, sel, we, stb, cyc, cti, bte,
    input  dat_sm, ack, err, rty
  );

  modport slave (
    input  adr, dat_ms, sel, we, stb, cyc, cti, bte,
    output dat_sm, ack, err, rty
  );
endinterface

// File: rtl/wb_arbiter_2m.sv
// Two-master round-robin Wishbone arbiter in front of a single BlockRAM slave.
// Whole bus cycles are granted; a watchdog turns a stalled strobe into an err termination.
module wb_arbiter_2m #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic   clk,
  input  logic   rst_n,
  wshb_if.slave  wb_m0,
  wshb_if.slave  wb_m1,
  wshb_if.master wb_s
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t        state;
  logic          last;
  logic [CW-1:0] wd_cnt;
  logic          wd_hit;
  logic          gnt_drop;
  logic          g_stb;

  assign gnt_drop = (state == GNT0 && !wb_m0.cyc) || (state == GNT1 && !wb_m1.cyc);
  assign wd_hit   = (TIMEOUT != 0) && (state != IDLE) && (wd_cnt == CW'(TIMEOUT));

  // Combinational routing: only the owner sees the slave; a watchdog hit masks stb/ack and injects err.
  always_comb begin
    wb_s.adr     = '0;
    wb_s.dat_ms  = '0;
    wb_s.sel     = '0;
    wb_s.we      = 1'b0;
    wb_s.stb     = 1'b0;
    wb_s.cyc     = 1'b0;
    wb_s.cti     = '0;
    wb_s.bte     = '0;
    wb_m0.dat_sm = '0;
    wb_m0.ack    = 1'b0;
    wb_m0.err    = 1'b0;
    wb_m0.rty    = 1'b0;
    wb_m1.dat_sm = '0;
    wb_m1.ack    = 1'b0;
    wb_m1.err    = 1'b0;
    wb_m1.rty    = 1'b0;
    g_stb        = 1'b0;
    if (state == GNT0) begin
      wb_s.adr     = wb_m0.adr;
      wb_s.dat_ms  = wb_m0.dat_ms;
      wb_s.sel     = wb_m0.sel;
      wb_s.we      = wb_m0.we;
      wb_s.stb     = wb_m0.stb & ~wd_hit;
      wb_s.cyc     = wb_m0.cyc;
      wb_s.cti     = wb_m0.cti;
      wb_s.bte     = wb_m0.bte;
      wb_m0.dat_sm = wb_s.dat_sm;
      wb_m0.ack    = wb_s.ack & ~wd_hit;
      wb_m0.err    = wb_s.err | wd_hit;
      wb_m0.rty    = wb_s.rty & ~wd_hit;
      g_stb        = wb_m0.stb;
    end else if (state == GNT1) begin
      wb_s.adr     = wb_m1.adr;
      wb_s.dat_ms  = wb_m1.dat_ms;
      wb_s.sel     = wb_m1.sel;
      wb_s.we      = wb_m1.we;
      wb_s.stb     = wb_m1.stb & ~wd_hit;
      wb_s.cyc     = wb_m1.cyc;
      wb_s.cti     = wb_m1.cti;
      wb_s.bte     = wb_m1.bte;
      wb_m1.dat_sm = wb_s.dat_sm;
      wb_m1.ack    = wb_s.ack & ~wd_hit;
      wb_m1.err    = wb_s.err | wd_hit;
      wb_m1.rty    = wb_s.rty & ~wd_hit;
      g_stb        = wb_m1.stb;
    end
  end

  // Grant FSM plus watchdog; last starts at 1 so master 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      last   <= 1'b1;
      wd_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (wb_m0.cyc && (!wb_m1.cyc || last)) state <= GNT0;
          else if (wb_m1.cyc)                     state <= GNT1;
        end
        GNT0: begin
          if (!wb_m0.cyc) begin
            last  <= 1'b0;
            state <= wb_m1.cyc ? GNT1 : IDLE;
          end
        end
        GNT1: begin
          if (!wb_m1.cyc) begin
            last  <= 1'b1;
            state <= wb_m0.cyc ? GNT0 : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (TIMEOUT == 0 || gnt_drop || !g_stb || wb_s.ack || wb_s.err || wd_hit) wd_cnt <= '0;
      else                                                                    wd_cnt <= wd_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed-plus-random bench for wb_arbiter_2m: a BlockRAM-like slave stub drives the shared port,
// and expected grants/data come from a round-robin rule and a word-array memory model.
module tb_wb_arbiter_2m;

  logic clk;
  logic rst_n;
  logic stall;
  int   vectors;
  int   miscompares;
  int   last_m;
  int   lock_acks;
  logic lock_mon;

  logic [31:0] ref_mem [0:255];
  logic [31:0] mem [0:255];
  logic        rd_ack_q;
  logic [31:0] rd_data_q;
  logic        s_req;

  wshb_if m0_bus ();
  wshb_if m1_bus ();
  wshb_if s_bus ();
  wshb_if n0_bus ();
  wshb_if n1_bus ();
  wshb_if ns_bus ();

  wb_arbiter_2m #(.TIMEOUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb_m0 (m0_bus),
    .wb_m1 (m1_bus),
    .wb_s  (s_bus)
  );

  wb_arbiter_2m #(.TIMEOUT(0)) dut_nowd (
    .clk   (clk),
    .rst_n (rst_n),
    .wb_m0 (n0_bus),
    .wb_m1 (n1_bus),
    .wb_s  (ns_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave stub: write ack in the strobe cycle, read ack one cycle later, never acks while stalled.
  assign s_req = s_bus.cyc & s_bus.stb;
  always_comb begin
    s_bus.ack = 1'b0;
    if (!stall && s_req) s_bus.ack = s_bus.we ? 1'b1 : rd_ack_q;
  end
  assign s_bus.err    = 1'b0;
  assign s_bus.rty    = 1'b0;
  assign s_bus.dat_sm = rd_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ack_q  <= 1'b0;
      rd_data_q <= '0;
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else begin
      rd_ack_q <= !stall && s_req && !s_bus.we && !rd_ack_q;
      if (s_req && !s_bus.we) rd_data_q <= mem[s_bus.adr[9:2]];
      if (!stall && s_req && s_bus.we)
        for (int b = 0; b < 4; b++)
          if (s_bus.sel[b]) mem[s_bus.adr[9:2]][8*b +: 8] <= s_bus.dat_ms[8*b +: 8];
    end
  end

  assign ns_bus.ack    = 1'b0;
  assign ns_bus.err    = 1'b0;
  assign ns_bus.rty    = 1'b0;
  assign ns_bus.dat_sm = '0;

  always begin
    @(negedge clk);
    #2;
    if (lock_mon && m0_bus.ack !== 1'b0) lock_acks++;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input int m, input logic cyc, input logic stb, input logic we,
                                input logic [31:0] adr, input logic [31:0] dat,
                                input logic [3:0] sel, input logic [2:0] cti);
    if (m == 0) begin
      m0_bus.cyc = cyc; m0_bus.stb = stb; m0_bus.we = we; m0_bus.adr = adr;
      m0_bus.dat_ms = dat; m0_bus.sel = sel; m0_bus.cti = cti; m0_bus.bte = 2'b00;
    end else begin
      m1_bus.cyc = cyc; m1_bus.stb = stb; m1_bus.we = we; m1_bus.adr = adr;
      m1_bus.dat_ms = dat; m1_bus.sel = sel; m1_bus.cti = cti; m1_bus.bte = 2'b00;
    end
  endtask

  task automatic release_bus(input int m);
    apply_stimulus(m, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
  endtask

  function automatic logic m_ack(input int m);
    return (m == 0) ? m0_bus.ack : m1_bus.ack;
  endfunction

  function automatic logic m_err(input int m);
    return (m == 0) ? m0_bus.err : m1_bus.err;
  endfunction

  function automatic logic [31:0] m_dat(input int m);
    return (m == 0) ? m0_bus.dat_sm : m1_bus.dat_sm;
  endfunction

  function automatic logic [31:0] rand_adr();
    return 32'h100 + 32'(4 * $urandom_range(0, 7));
  endfunction

  task automatic model_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    for (int b = 0; b < 4; b++)
      if (sel[b]) ref_mem[adr[9:2]][8*b +: 8] = dat[8*b +: 8];
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    last_m = 1;
  endtask

  // One beat: drive at the falling edge, then wait (bounded) for ack/err; lat counts waiting cycles.
  task automatic beat(input int m, input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input logic [2:0] cti,
                      output logic [31:0] rdata, output int lat, output logic got_err);
    logic done;
    done = 1'b0; lat = 0; rdata = '0; got_err = 1'b0;
    @(negedge clk);
    apply_stimulus(m, 1'b1, 1'b1, we, adr, dat, sel, cti);
    #1;
    while (!done && lat < 20) begin
      if (m_ack(m) || m_err(m)) begin
        done = 1'b1; rdata = m_dat(m); got_err = m_err(m);
      end else begin
        lat++;
        @(negedge clk);
        #1;
      end
    end
  endtask

  initial begin
    logic [31:0] d0, d1, a0, a1, rd;
    int          win, lat, nw_errs;
    logic        e;
    vectors = 0; miscompares = 0; lock_acks = 0; lock_mon = 1'b0; nw_errs = 0;
    stall = 1'b0;
    rst_n = 1'b0;
    release_bus(0);
    release_bus(1);
    {n0_bus.cyc, n0_bus.stb, n0_bus.we, n0_bus.adr, n0_bus.dat_ms, n0_bus.sel, n0_bus.cti, n0_bus.bte} = '0;
    {n1_bus.cyc, n1_bus.stb, n1_bus.we, n1_bus.adr, n1_bus.dat_ms, n1_bus.sel, n1_bus.cti, n1_bus.bte} = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_output("rst_s_cyc", s_bus.cyc, 0);
    check_output("rst_s_stb", s_bus.stb, 0);
    check_output("rst_m0_ack", m0_bus.ack, 0);
    check_output("rst_m1_dat", m1_bus.dat_sm, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Tie right after reset, then handover to the loser with no idle bubble.
    @(negedge clk);
    d0 = $urandom; d1 = $urandom; a0 = rand_adr(); a1 = rand_adr();
    apply_stimulus(0, 1'b1, 1'b1, 1'b1, a0, d0, 4'hF, 3'b000);
    apply_stimulus(1, 1'b1, 1'b1, 1'b1, a1, d1, 4'hF, 3'b000);
    #1 check_output("tie0_idle_cyc", s_bus.cyc, 0);
    win = 1 - last_m;
    @(negedge clk);
    #1 check_output("tie0_win_ack", m_ack(win), 1);
    check_output("tie0_lose_ack", m_ack(1 - win), 0);
    model_write(win == 0 ? a0 : a1, win == 0 ? d0 : d1, 4'hF);
    @(negedge clk);
    release_bus(win);
    #1 check_output("handover_gap_ack", m_ack(1 - win), 0);
    @(negedge clk);
    #1 check_output("handover_ack", m_ack(1 - win), 1);
    model_write(win == 0 ? a1 : a0, win == 0 ? d1 : d0, 4'hF);
    @(negedge clk);
    release_bus(1 - win);
    last_m = 1 - win;

    // Four tie rounds where both drop together; ownership must alternate.
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      d0 = $urandom; d1 = $urandom; a0 = rand_adr(); a1 = rand_adr();
      apply_stimulus(0, 1'b1, 1'b1, 1'b1, a0, d0, 4'hF, 3'b000);
      apply_stimulus(1, 1'b1, 1'b1, 1'b1, a1, d1, 4'hF, 3'b000);
      #1 check_output($sformatf("alt%0d_idle", r), s_bus.cyc, 0);
      win = 1 - last_m;
      @(negedge clk);
      #1 check_output($sformatf("alt%0d_win_ack", r), m_ack(win), 1);
      check_output($sformatf("alt%0d_lose_ack", r), m_ack(1 - win), 0);
      check_output($sformatf("alt%0d_dat_fwd", r), s_bus.dat_ms, win == 0 ? d0 : d1);
      model_write(win == 0 ? a0 : a1, win == 0 ? d0 : d1, 4'hF);
      @(negedge clk);
      release_bus(0);
      release_bus(1);
      last_m = win;
    end

    // Single master write then read of the same word.
    @(negedge clk);
    apply_stimulus(0, 1'b1, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b000);
    #1 check_output("sm_latency_cyc", s_bus.cyc, 0);
    check_output("sm_latency_ack", m0_bus.ack, 0);
    @(negedge clk);
    #1 check_output("sm_wr_ack", m0_bus.ack, 1);
    check_output("sm_m1_ack_wr", m1_bus.ack, 0);
    model_write(32'h10, 32'hDEADBEEF, 4'hF);
    beat(0, 1'b0, 32'h10, 32'h0, 4'hF, 3'b000, rd, lat, e);
    check_output("sm_rd_lat", lat, 1);
    check_output("sm_rd_data", rd, ref_mem[4]);
    check_output("sm_m1_ack_rd", m1_bus.ack, 0);
    @(negedge clk);
    release_bus(0);
    last_m = 0;

    // Byte-lane merge through the arbiter.
    beat(1, 1'b1, 32'h20, 32'hAABBCCDD, 4'hF, 3'b000, rd, lat, e);
    check_output("be_first_lat", lat, 1);
    model_write(32'h20, 32'hAABBCCDD, 4'hF);
    beat(1, 1'b1, 32'h20, 32'h11223344, 4'b0101, 3'b000, rd, lat, e);
    check_output("be_wr_lat", lat, 0);
    model_write(32'h20, 32'h11223344, 4'b0101);
    beat(1, 1'b0, 32'h20, 32'h0, 4'hF, 3'b000, rd, lat, e);
    check_output("be_readback", rd, ref_mem[8]);
    check_output("be_merge_value", rd, 32'hAA22CC44);
    @(negedge clk);
    release_bus(1);
    last_m = 1;

    // m1 holds the bus for an 8-beat incrementing read while m0 waits.
    beat(1, 1'b0, 32'h100, 32'h0, 4'hF, 3'b010, rd, lat, e);
    check_output("lock_first_lat", lat, 2);
    check_output("lock_beat0", rd, ref_mem[32'h100 >> 2]);
    d0 = $urandom;
    apply_stimulus(0, 1'b1, 1'b1, 1'b1, 32'h40, d0, 4'hF, 3'b000);
    lock_mon = 1'b1;
    for (int k = 1; k < 8; k++) begin
      beat(1, 1'b0, 32'h100 + 32'(4 * k), 32'h0, 4'hF, (k == 7) ? 3'b111 : 3'b010, rd, lat, e);
      check_output($sformatf("lock_beat%0d", k), rd, ref_mem[(32'h100 >> 2) + k]);
    end
    @(negedge clk);
    release_bus(1);
    #1 check_output("lock_release_m0_ack", m0_bus.ack, 0);
    lock_mon = 1'b0;
    check_output("lock_m0_no_ack", lock_acks, 0);
    @(negedge clk);
    #1 check_output("lock_handover_ack", m0_bus.ack, 1);
    model_write(32'h40, d0, 4'hF);
    @(negedge clk);
    release_bus(0);
    last_m = 0;

    // Watchdog (TIMEOUT=4) against a slave that never answers.
    @(negedge clk);
    stall = 1'b1;
    apply_stimulus(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 3'b000);
    #1 check_output("wd_idle_stb", s_bus.stb, 0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      #1;
      check_output($sformatf("wd_err%0d", k), m0_bus.err, (k == 5) ? 1 : 0);
      check_output($sformatf("wd_stb%0d", k), s_bus.stb, (k == 5) ? 0 : 1);
      check_output($sformatf("wd_ack%0d", k), m0_bus.ack, 0);
    end
    @(negedge clk);
    release_bus(0);
    stall = 1'b0;
    last_m = 0;

    // TIMEOUT=0 instance: a stalled strobe must never be terminated.
    @(negedge clk);
    n0_bus.cyc = 1'b1; n0_bus.stb = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      #1;
      if (n0_bus.err !== 1'b0) nw_errs++;
    end
    check_output("nowd_err_count", nw_errs, 0);
    check_output("nowd_stb_held", ns_bus.stb, 1);
    @(negedge clk);
    n0_bus.cyc = 1'b0; n0_bus.stb = 1'b0;

    // Async reset in the middle of a GNT1 read.
    @(negedge clk);
    apply_stimulus(1, 1'b1, 1'b1, 1'b0, 32'h104, 32'h0, 4'hF, 3'b010);
    @(negedge clk);
    #1 check_output("arst_pre_cyc", s_bus.cyc, 1);
    #2 rst_n = 1'b0;
    #1 check_output("arst_cyc", s_bus.cyc, 0);
    check_output("arst_stb", s_bus.stb, 0);
    check_output("arst_m1_ack", m1_bus.ack, 0);
    @(negedge clk);
    #1 check_output("arst_hold_ack", m1_bus.ack, 0);
    @(negedge clk);
    release_bus(1);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    d0 = $urandom; d1 = $urandom;
    apply_stimulus(0, 1'b1, 1'b1, 1'b1, rand_adr(), d0, 4'hF, 3'b000);
    apply_stimulus(1, 1'b1, 1'b1, 1'b1, rand_adr(), d1, 4'hF, 3'b000);
    win = 1 - last_m;
    @(negedge clk);
    #1 check_output("arst_tie_win", m_ack(win), 1);
    check_output("arst_tie_lose", m_ack(1 - win), 0);
    @(negedge clk);
    release_bus(0);
    release_bus(1);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
